// File: rtl/oled_spi_scheduler.sv
// oled_spi_scheduler: shares one OLED SPI write port (mode 0, MSB first)
// between two byte-stream requesters with round-robin burst arbitration.
module oled_spi_scheduler #(
   parameter int CLK_DIV = 2
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Req0,
   input  logic       Req1,
   input  logic [7:0] Byte0,
   input  logic [7:0] Byte1,
   input  logic       DnC0,
   input  logic       DnC1,
   input  logic       Last0,
   input  logic       Last1,
   output logic       Ack0,
   output logic       Ack1,
   output logic [1:0] Grant,
   output logic       Busy,
   output logic       SCLK,
   output logic       nCS,
   output logic       DnC,
   output logic       SDIN
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          sclk_q, sclk_d;
   logic          ncs_q, ncs_d;
   logic          dnc_q, dnc_d;
   logic          last_q, last_d;
   logic          owner_q, owner_d;
   logic          rr_q, rr_d;
   logic          busy_q, busy_d;
   logic [1:0]    ack_q, ack_d;
   logic [1:0]    grant_q, grant_d;

   logic       div_done;
   logic       bit_end;
   logic       byte_done;
   logic       req_any;
   logic       win_sel;
   logic       sel;
   logic       sel_req;
   logic [7:0] sel_byte;
   logic       sel_dnc;
   logic       sel_last;
   logic       load;

   always_comb begin
      div_done  = (div_q == DIV_MAX);
      bit_end   = (state_q == SHIFT)
                  && sclk_q && div_done;
      byte_done = bit_end && (bit_q == 3'd0);
      req_any   = Req0 | Req1;
      // rr_q holds the most recent owner
      win_sel   = (Req0 & Req1) ? ~rr_q : Req1;
      sel       = (state_q == IDLE) ? win_sel
                                    : owner_q;
      sel_req   = sel ? Req1 : Req0;
      sel_byte  = sel ? Byte1 : Byte0;
      sel_dnc   = sel ? DnC1 : DnC0;
      sel_last  = sel ? Last1 : Last0;
      load      = ((state_q == IDLE) && req_any)
                  || (byte_done && !last_q && sel_req)
                  || ((state_q == HOLD) && sel_req);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= 3'd0;
         shreg_q <= 8'h00;
         sclk_q  <= 1'b0;
         ncs_q   <= 1'b1;
         dnc_q   <= 1'b0;
         last_q  <= 1'b0;
         owner_q <= 1'b0;
         rr_q    <= 1'b1;
         busy_q  <= 1'b0;
         ack_q   <= 2'b00;
         grant_q <= 2'b00;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         sclk_q  <= sclk_d;
         ncs_q   <= ncs_d;
         dnc_q   <= dnc_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         grant_q <= grant_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (req_any) state_d = SHIFT;
         end
         SHIFT: begin
            if (byte_done) begin
               if (last_q)       state_d = GAP;
               else if (sel_req) state_d = SHIFT;
               else              state_d = HOLD;
            end
         end
         HOLD: begin
            if (sel_req) state_d = SHIFT;
         end
         GAP: begin
            if (div_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      div_d   = '0;
      sclk_d  = 1'b0;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      ncs_d   = ncs_q;
      dnc_d   = dnc_q;
      last_d  = last_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      grant_d = grant_q;
      ack_d   = 2'b00;
      busy_d  = (state_d != IDLE);
      unique case (state_q)
         SHIFT: begin
            div_d  = div_done ? '0
                              : div_q + DW'(1);
            sclk_d = div_done ? ~sclk_q : sclk_q;
            if (bit_end && (bit_q != 3'd0)) begin
               bit_d   = bit_q - 3'd1;
               shreg_d = {shreg_q[6:0], 1'b0};
            end
            if (byte_done && last_q) ncs_d = 1'b1;
         end
         GAP: begin
            div_d = div_done ? '0
                             : div_q + DW'(1);
            if (div_done) begin
               grant_d = 2'b00;
               rr_d    = owner_q;
            end
         end
         default: ;
      endcase
      if (load) begin
         div_d   = '0;
         sclk_d  = 1'b0;
         bit_d   = 3'd7;
         shreg_d = sel_byte;
         ncs_d   = 1'b0;
         dnc_d   = sel_dnc;
         last_d  = sel_last;
         owner_d = sel;
         grant_d = sel ? 2'b10 : 2'b01;
         ack_d   = sel ? 2'b10 : 2'b01;
      end
   end

   assign Ack0  = ack_q[0];
   assign Ack1  = ack_q[1];
   assign Grant = grant_q;
   assign Busy  = busy_q;
   assign SCLK  = sclk_q;
   assign nCS   = ncs_q;
   assign DnC   = dnc_q;
   assign SDIN  = shreg_q[7];

endmodule

// File: tb/tb_oled_spi_scheduler.sv
// Bench for oled_spi_scheduler: vector table, scoreboard on the serial
// stream, and hand-written arbitration/burst/stall/reset sequences.
module tb_oled_spi_scheduler;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       req0, req1;
   logic [7:0] byte0, byte1;
   logic       dnc0, dnc1, last0, last1;
   logic       ack0, ack1;
   logic [1:0] grant;
   logic       busy, sclk, ncs, dnc, sdin;

   logic       u_req0, u_dnc0, u_last0;
   logic [7:0] u_byte0;
   logic       z1 = 1'b0;
   logic [7:0] z8 = 8'h00;
   logic       u_ack0, u_ack1, u_busy;
   logic       u_sclk, u_ncs, u_dnc, u_sdin;
   logic [1:0] u_grant;

   oled_spi_scheduler #(.CLK_DIV(2)) dut (
      .Clock(clk), .Reset(rst),
      .Req0(req0), .Req1(req1),
      .Byte0(byte0), .Byte1(byte1),
      .DnC0(dnc0), .DnC1(dnc1),
      .Last0(last0), .Last1(last1),
      .Ack0(ack0), .Ack1(ack1),
      .Grant(grant), .Busy(busy),
      .SCLK(sclk), .nCS(ncs),
      .DnC(dnc), .SDIN(sdin)
   );

   oled_spi_scheduler #(.CLK_DIV(1)) dut1 (
      .Clock(clk), .Reset(rst),
      .Req0(u_req0), .Req1(z1),
      .Byte0(u_byte0), .Byte1(z8),
      .DnC0(u_dnc0), .DnC1(z1),
      .Last0(u_last0), .Last1(z1),
      .Ack0(u_ack0), .Ack1(u_ack1),
      .Grant(u_grant), .Busy(u_busy),
      .SCLK(u_sclk), .nCS(u_ncs),
      .DnC(u_dnc), .SDIN(u_sdin)
   );

   typedef struct {
      logic [7:0] b;
      logic [1:0] g;
      logic       d;
   } exp_t;

   typedef struct {
      int         r;
      logic [7:0] b;
      logic       d;
      logic [1:0] g;
   } vec_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm,
                      input int act,
                      input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h",
                  nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int r,
                        input logic rq,
                        input logic [7:0] b,
                        input logic d,
                        input logic l);
      if (r == 0) begin
         req0 = rq; byte0 = b; dnc0 = d; last0 = l;
      end else begin
         req1 = rq; byte1 = b; dnc1 = d; last1 = l;
      end
   endtask

   task automatic push_exp(input logic [7:0] b,
                           input logic [1:0] g,
                           input logic d);
      exp_t e;
      e.b = b; e.g = g; e.d = d;
      sbq.push_back(e);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 500) begin
         tick();
         n++;
      end
      if (busy) chk("idle_timeout", 1, 0);
   endtask

   // serial monitor: rebuild each byte from SDIN at SCLK rises
   logic [7:0] msr = 8'h00;
   int         mbits = 0;
   logic [1:0] mg = 2'b00;
   logic       md = 1'b0;
   logic       sclk_prev = 1'b0;

   always @(negedge clk) begin
      if (rst || ncs) begin
         mbits = 0;
      end else if (sclk && !sclk_prev) begin
         msr = {msr[6:0], sdin};
         mbits++;
         if (mbits == 1) begin
            mg = grant;
            md = dnc;
         end
         if (mbits == 8) begin
            mbits = 0;
            if (sbq.size() == 0) begin
               chk("sb_unexpected_byte", 1, 0);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("sb_byte", msr, e.b);
               chk("sb_grant", mg, e.g);
               chk("sb_dnc", md, e.d);
            end
         end
      end
      sclk_prev = sclk;
   end

   initial begin
      vec_t       vt[6];
      logic [7:0] b0[2], b1[2], bs[3];
      int         ord[4], eo[4];
      int         a1[3];
      int         i0, i1, k, n, gap, extra;
      int         idx, a0, gaps, a, a2;
      int         hold_bad, g_bad, tog_bad, ones;
      logic       prev;

      vt[0] = '{0, 8'hA5, 1'b0, 2'b01};
      vt[1] = '{1, 8'h5A, 1'b1, 2'b10};
      vt[2] = '{0, 8'h00, 1'b1, 2'b01};
      vt[3] = '{1, 8'hFF, 1'b0, 2'b10};
      vt[4] = '{0, 8'h80, 1'b0, 2'b01};
      vt[5] = '{1, 8'h01, 1'b1, 2'b10};

      rst = 1'b1;
      drive(0, 0, 8'h00, 0, 0);
      drive(1, 0, 8'h00, 0, 0);
      u_req0 = 0; u_byte0 = 8'h00;
      u_dnc0 = 0; u_last0 = 0;
      tick();
      tick();
      chk("rst_ncs", ncs, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_sdin", sdin, 0);
      chk("rst_dnc", dnc, 0);
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ack", {ack1, ack0}, 0);
      chk("rst_u1_ncs", u_ncs, 1);
      rst = 1'b0;
      tick();

      // arbitration from reset: 0,1,0,1
      b0[0] = 8'h11; b0[1] = 8'h22;
      b1[0] = 8'h33; b1[1] = 8'h44;
      eo[0] = 0; eo[1] = 1; eo[2] = 0; eo[3] = 1;
      for (int j = 0; j < 4; j++) ord[j] = -1;
      push_exp(8'h11, 2'b01, 1'b0);
      push_exp(8'h33, 2'b10, 1'b1);
      push_exp(8'h22, 2'b01, 1'b0);
      push_exp(8'h44, 2'b10, 1'b1);
      i0 = 0; i1 = 0; k = 0;
      drive(0, 1, b0[0], 0, 1);
      drive(1, 1, b1[0], 1, 1);
      for (int t = 0; t < 2000 && k < 4; t++) begin
         tick();
         if (ack0) begin
            if (k < 4) ord[k] = 0;
            k++; i0++;
            if (i0 < 2) drive(0, 1, b0[i0], 0, 1);
            else        drive(0, 0, 8'h00, 0, 0);
         end
         if (ack1) begin
            if (k < 4) ord[k] = 1;
            k++; i1++;
            if (i1 < 2) drive(1, 1, b1[i1], 1, 1);
            else        drive(1, 0, 8'h00, 0, 0);
         end
      end
      chk("arb_count", k, 4);
      for (int j = 0; j < 4; j++)
         chk("arb_order", ord[j], eo[j]);
      wait_idle();

      // single-byte vectors
      for (int v = 0; v < 6; v++) begin
         wait_idle();
         drive(vt[v].r, 1, vt[v].b, vt[v].d, 1);
         push_exp(vt[v].b, vt[v].g, vt[v].d);
         tick();
         chk("vec_ack", {ack1, ack0}, vt[v].g);
         chk("vec_grant", grant, vt[v].g);
         chk("vec_ncs", ncs, 0);
         chk("vec_msb", sdin, vt[v].b[7]);
         chk("vec_dnc", dnc, vt[v].d);
         drive(vt[v].r, 0, 8'h00, 0, 0);
         n = 1; extra = 0;
         while (n < 200) begin
            tick();
            if (ncs) break;
            if (ack0 || ack1) extra++;
            n++;
         end
         chk("vec_ncs_low", n, 32);
         chk("vec_extra_ack", extra, 0);
         gap = 0;
         while (busy && gap < 50) begin
            if (!ncs) extra++;
            gap++;
            tick();
         end
         chk("vec_gap", gap, 2);
         chk("vec_gap_ncs", extra, 0);
         chk("vec_grant_free", grant, 0);
      end

      // burst on requester 1, requester 0 arrives mid-burst
      wait_idle();
      bs[0] = 8'h12; bs[1] = 8'h34; bs[2] = 8'h56;
      push_exp(8'h12, 2'b10, 1'b1);
      push_exp(8'h34, 2'b10, 1'b1);
      push_exp(8'h56, 2'b10, 1'b1);
      push_exp(8'hC3, 2'b01, 1'b0);
      for (int j = 0; j < 3; j++) a1[j] = 0;
      idx = 0; a0 = -1; gaps = 0;
      drive(1, 1, bs[0], 1, 0);
      for (int t = 0; t < 600 && a0 < 0; t++) begin
         tick();
         if (idx > 0 && ncs && cyc < a1[0] + 96)
            gaps++;
         if (ack0) begin
            a0 = cyc;
            drive(0, 0, 8'h00, 0, 0);
         end
         if (ack1) begin
            if (idx < 3) a1[idx] = cyc;
            idx++;
            if (idx == 1) drive(0, 1, 8'hC3, 0, 1);
            if (idx < 3)
               drive(1, 1, bs[idx], 1, logic'(idx == 2));
            else
               drive(1, 0, 8'h00, 0, 0);
         end
      end
      chk("burst_acks", idx, 3);
      chk("burst_sp1", a1[1] - a1[0], 32);
      chk("burst_sp2", a1[2] - a1[1], 32);
      chk("burst_ncs_gaps", gaps, 0);
      chk("burst_ack0_at", a0 - a1[0], 99);
      wait_idle();

      // stall into HOLD, requester 1 ignored while held
      push_exp(8'h3C, 2'b01, 1'b0);
      push_exp(8'h81, 2'b01, 1'b1);
      push_exp(8'h99, 2'b10, 1'b0);
      drive(0, 1, 8'h3C, 0, 0);
      tick();
      chk("stall_ack", ack0, 1);
      a = cyc;
      drive(0, 0, 8'h81, 1, 1);
      hold_bad = 0; g_bad = 0;
      for (int t = 0; t < 42; t++) begin
         tick();
         if (cyc >= a + 32) begin
            if (ncs || sclk || !busy) hold_bad++;
            if (ack0 || ack1) hold_bad++;
            if (grant != 2'b01) g_bad++;
         end
         if (cyc == a + 35) drive(1, 1, 8'h99, 0, 1);
      end
      chk("hold_lines", hold_bad, 0);
      chk("hold_grant", g_bad, 0);
      drive(0, 1, 8'h81, 1, 1);
      tick();
      chk("stall_resume_ack", ack0, 1);
      chk("stall_resume_dnc", dnc, 1);
      a2 = cyc;
      drive(0, 0, 8'h00, 0, 0);
      n = 0;
      while (!ack1 && n < 200) begin
         tick();
         n++;
      end
      chk("stall_other_ack", cyc - a2, 35);
      drive(1, 0, 8'h00, 0, 0);
      wait_idle();

      // reset during bit 4, then tie from reset
      drive(1, 1, 8'hDB, 1, 1);
      tick();
      chk("mid_ack", ack1, 1);
      a = cyc;
      drive(1, 0, 8'h00, 0, 0);
      while (cyc < a + 13) tick();
      chk("mid_bit4_sdin", sdin, 1);
      rst = 1'b1;
      tick();
      chk("mid_rst_ncs", ncs, 1);
      chk("mid_rst_sclk", sclk, 0);
      chk("mid_rst_sdin", sdin, 0);
      chk("mid_rst_grant", grant, 0);
      chk("mid_rst_busy", busy, 0);
      rst = 1'b0;
      push_exp(8'h4B, 2'b01, 1'b0);
      push_exp(8'h6D, 2'b10, 1'b1);
      drive(0, 1, 8'h4B, 0, 1);
      drive(1, 1, 8'h6D, 1, 1);
      tick();
      chk("post_rst_tie", {ack1, ack0}, 1);
      chk("post_rst_grant", grant, 1);
      drive(0, 0, 8'h00, 0, 0);
      n = 0;
      while (!ack1 && n < 200) begin
         tick();
         n++;
      end
      chk("post_rst_req1", ack1, 1);
      drive(1, 0, 8'h00, 0, 0);
      wait_idle();

      // CLK_DIV = 1
      u_req0 = 1; u_byte0 = 8'hFF;
      u_dnc0 = 1; u_last0 = 1;
      tick();
      chk("d1_ack", {u_ack1, u_ack0}, 1);
      chk("d1_grant", u_grant, 1);
      chk("d1_dnc", u_dnc, 1);
      chk("d1_sclk0", u_sclk, 0);
      u_req0 = 0;
      n = 0; tog_bad = 0; ones = 0; prev = u_sclk;
      while (!u_ncs && n < 100) begin
         n++;
         if (u_sclk) ones += int'(u_sdin);
         if (n > 1 && u_sclk == prev) tog_bad++;
         prev = u_sclk;
         tick();
      end
      chk("d1_ncs_low", n, 16);
      chk("d1_toggle", tog_bad, 0);
      chk("d1_ones", ones, 8);
      chk("d1_gap_busy", u_busy, 1);
      tick();
      chk("d1_idle", {u_busy, u_grant}, 0);

      wait_idle();
      repeat (4) tick();
      chk("sb_drain", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule

// File: doc/oled_spi_scheduler.md
# oled_spi_scheduler

Shares the single OLED SPI write port (SCLK, nCS, DnC, SDIN) of the cycle computer between two byte-stream requesters. Requester 0 is the display command/initialisation sequencer; requester 1 is the frame-refresh data engine. The block serialises bytes MSB-first in SPI mode 0. It keeps nCS asserted across a multi-byte burst and arbitrates round-robin between bursts. It sits in comp_core between the display logic and the SCLK/nCS/DnC/SDIN pad drivers.

## Interface
- CLK_DIV, 2, number of Clock cycles per SCLK half-period; minimum 1
- Clock  input  1  system clock; all logic on rising edge
- Reset  input  1  synchronous, active-high reset
- Req0 / Req1  input  1  requester has a byte valid; held until its Ack
- Byte0 / Byte1  input  8  byte to send
- DnC0 / DnC1  input  1  0 = command, 1 = data; value driven on DnC for that byte
- Last0 / Last1  input  1  byte is the final byte of the burst
- Ack0 / Ack1  output  1  one-cycle pulse: byte accepted into shifter
- Grant  output  2  one-hot owner of the port; 00 when free
- Busy  output  1  high whenever state ≠ IDLE
- SCLK  output  1  SPI clock, idles low
- nCS  output  1  chip select, active-low
- DnC  output  1  command/data select
- SDIN  output  1  serial data, MSB first

## Operation
- All outputs are registered.
- Reset values: SCLK=0, nCS=1, DnC=0, SDIN=0, Ack0=Ack1=0, Grant=00, Busy=0, state=IDLE, round-robin pointer favours requester 0.
- States: IDLE, SHIFT, HOLD, GAP.
- IDLE
  - One request only: that requester wins.
  - Both requesting: the requester not granted most recently wins.
  - On the win: load the shifter with the winner's Byte, set DnC from its DnCx, set its Grant bit, drive nCS=0 and SDIN=Byte[7], pulse its Ack, go to SHIFT.
- SHIFT
  - Eight bits; each bit is CLK_DIV cycles with SCLK low, then CLK_DIV cycles with SCLK high.
  - SDIN changes only while SCLK is low, at the start of each bit; it is stable across the rising edge.
  - The bit counter is 3 bits and must not wrap into a ninth bit.
- End of byte (last SCLK-high cycle of bit 0):
  - Byte had Last=0 and the granted Req=1 at that edge: load the next byte and pulse Ack in the following cycle, which is the first SCLK-low cycle of the new byte. nCS stays low with no gap cycles.
  - Byte had Last=0 and Req=0: go to HOLD.
  - Byte had Last=1: go to GAP.
- HOLD
  - nCS=0, SCLK=0; Grant stays locked, and the other requester is ignored even if it requests.
  - When the granted Req is seen, load the byte and pulse Ack in the next cycle, then return to SHIFT.
- GAP
  - nCS=1, SCLK=0 for CLK_DIV cycles.
  - Then clear Grant, update the round-robin pointer to the just-finished owner, and go to IDLE.
- DnC may change between bytes of one burst; it changes only in a byte's first cycle.
- Req of the non-granted requester has no effect until IDLE. Its Byte, DnC and Last are never sampled outside IDLE.
- Reset in any state forces the reset values on the next edge. A partial byte is abandoned; no Ack is issued for it beyond any already pulsed.

## Timing
- Latency: Req sampled high in IDLE at edge t → nCS=0, Ack=1, SDIN=MSB in cycle t+1.
- One byte holds nCS low for exactly 16×CLK_DIV cycles.
- Single-byte burst occupancy: 16×CLK_DIV + CLK_DIV cycles, plus 1 IDLE cycle before the next grant.
- Ack pulses of one requester are at least 16×CLK_DIV cycles apart. A requester may present its next byte in the cycle after Ack.
- SCLK rising edges fall in the middle of each SDIN bit: CLK_DIV cycles after SDIN changes.

## Test plan
- Single byte: CLK_DIV=2; Req0 with Byte0=0xA5, DnC0=0, Last0=1 → Ack0 pulses once in the first nCS-low cycle; nCS is low for 32 cycles; SDIN sampled on the 8 SCLK rises reads 1,0,1,0,0,1,0,1; DnC=0; nCS is high for 2 cycles; Grant returns to 00.
- Arbitration: Req0 and Req1 asserted in the same cycle from reset → requester 0 served first. With both still requesting, the next grant goes to requester 1, then requester 0 again.
- Burst: Req1 sends 0x12, 0x34, 0x56 with DnC1=1 and Last on 0x56 only → nCS stays low for 3×32 cycles with no gaps; three Ack1 pulses 32 cycles apart; Req0 asserted mid-burst gets no Ack0 until after GAP.
- Stall: burst with Last=0 and Req0 dropped for 10 cycles after Ack → HOLD with nCS=0 and SCLK=0 for the stall; the next byte starts one cycle after Req0 returns.
- Reset mid-byte: Reset asserted during bit 4 → the next cycle shows nCS=1, SCLK=0, SDIN=0, Grant=00, Busy=0. After release, a fresh Req1 is granted normally, with round-robin favouring requester 0 on a tie.
- CLK_DIV=1: byte 0xFF → 16-cycle nCS-low window; SCLK toggles every cycle.
